// File: rtl/prog_sec_timer.sv
// Programmable seconds timer: prescaler -> tick counter -> seconds down-counter,
// one-shot or auto-reload. Define TIMER_SEC_LEFT_EN to expose the sec_left output.
module prog_sec_timer #(
    parameter int CLKS_PER_TICK = 50000,
    parameter int TICKS_PER_SEC = 1000,
    parameter int SEC_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic [SEC_W-1:0] limit,
    input  logic             periodic,
    output logic             timeout,
    output logic             busy,
`ifdef TIMER_SEC_LEFT_EN
    output logic [SEC_W-1:0] sec_left,
`endif
    output logic             expired
);

    localparam int PW = $clog2(CLKS_PER_TICK);
    localparam int TW = $clog2(TICKS_PER_SEC);

    localparam logic [PW-1:0]    PRE_MAX  = PW'(CLKS_PER_TICK - 1);
    localparam logic [TW-1:0]    TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [SEC_W-1:0] lim_q, lim_d;
    logic             per_q, per_d;
    logic             timeout_q, timeout_d;

    logic run_en;
    logic pre_wrap;
    logic tick_wrap;
    logic sec_wrap;
    logic last_sec;

    assign run_en    = (state_q == RUN) && enable;
    assign pre_wrap  = (pre_q == PRE_MAX);
    assign tick_wrap = (tick_q == TICK_MAX);
    assign sec_wrap  = run_en && pre_wrap && tick_wrap;
    assign last_sec  = sec_wrap && (sec_q == SEC_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            tick_q    <= '0;
            sec_q     <= '0;
            lim_q     <= '0;
            per_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            sec_q     <= sec_d;
            lim_q     <= lim_d;
            per_q     <= per_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (limit == '0) ? EXPIRED : RUN;
        end else if (stop) begin
            state_d = IDLE;
        end else if (state_q == RUN && last_sec && !per_q) begin
            state_d = EXPIRED;
        end
    end

    // Counter datapath
    always_comb begin
        pre_d     = pre_q;
        tick_d    = tick_q;
        sec_d     = sec_q;
        lim_d     = lim_q;
        per_d     = per_q;
        timeout_d = 1'b0;
        if (start) begin
            // The start cycle is itself the first counted cycle, which puts
            // the expiry pulse exactly limit seconds' worth of cycles later.
            pre_d     = (limit == '0) ? '0 : PW'(1);
            tick_d    = '0;
            sec_d     = limit;
            lim_d     = limit;
            per_d     = periodic;
            timeout_d = (limit == '0);
        end else if (stop) begin
            pre_d  = '0;
            tick_d = '0;
            sec_d  = '0;
            lim_d  = '0;
            per_d  = 1'b0;
        end else if (run_en) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
            if (pre_wrap) begin
                tick_d = tick_wrap ? '0 : tick_q + TW'(1);
            end
            if (sec_wrap) begin
                if (last_sec) begin
                    timeout_d = 1'b1;
                    sec_d     = per_q ? lim_q : '0;
                end else begin
                    sec_d = sec_q - SEC_ONE;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        timeout = timeout_q;
        busy    = (state_q == RUN);
        expired = (state_q == EXPIRED);
`ifdef TIMER_SEC_LEFT_EN
        sec_left = (state_q == RUN) ? sec_q : '0;
`endif
    end

endmodule

// File: tb/tb_prog_sec_timer.sv
// Scoreboard bench for prog_sec_timer at 4 clocks/tick, 5 ticks/s (20 cycles per second).
module tb_prog_sec_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start;
    logic       stop;
    logic [3:0] limit;
    logic       periodic;
    logic       timeout;
    logic       busy;
    logic       expired;
`ifdef TIMER_SEC_LEFT_EN
    logic [3:0] sec_left;
`endif

    prog_sec_timer #(
        .CLKS_PER_TICK(4),
        .TICKS_PER_SEC(5),
        .SEC_W(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .start   (start),
        .stop    (stop),
        .limit   (limit),
        .periodic(periodic),
        .timeout (timeout),
        .busy    (busy),
`ifdef TIMER_SEC_LEFT_EN
        .sec_left(sec_left),
`endif
        .expired (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         k;
        logic       to;
        logic       bz;
        logic       ex;
        logic       has_sec;
        logic [3:0] sec;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge
    task automatic drive(input logic rs, input logic st, input logic sp, input logic en,
                         input logic [3:0] lim, input logic per);
        @(posedge clk);
        #1;
        rst      = rs;
        start    = st;
        stop     = sp;
        enable   = en;
        limit    = lim;
        periodic = per;
    endtask

    task automatic push(input string tag, input int k, input logic to, input logic bz,
                        input logic ex, input logic has_sec, input logic [3:0] sec);
        exp_t e;
        e.tag = tag; e.k = k; e.to = to; e.bz = bz; e.ex = ex;
        e.has_sec = has_sec; e.sec = sec;
        sbq.push_back(e);
    endtask

    task automatic reset_idle(input string tag);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        push(tag, -1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(15));
    endfunction

    // Compare in the middle of the cycle the expectation was pushed in
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("%s.timeout@%0d", e.tag, e.k), 32'(timeout), 32'(e.to));
            chk($sformatf("%s.busy@%0d", e.tag, e.k), 32'(busy), 32'(e.bz));
            chk($sformatf("%s.expired@%0d", e.tag, e.k), 32'(expired), 32'(e.ex));
`ifdef TIMER_SEC_LEFT_EN
            if (e.has_sec)
                chk($sformatf("%s.sec_left@%0d", e.tag, e.k), 32'(sec_left), 32'(e.sec));
`endif
        end
    end

    initial begin
        logic [3:0] s;
        rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; limit = '0; periodic = 1'b0;

        // One-shot, limit 3; limit/periodic scrambled after start must not matter
        reset_idle("s1rst");
        for (int k = 0; k <= 70; k++) begin
            drive(1'b0, k == 0, 1'b0, 1'b1, (k == 0) ? 4'd3 : rnd4(),
                  (k == 0) ? 1'b0 : 1'($urandom_range(1)));
            s = (k < 1) ? 4'd0 : (k < 20) ? 4'd3 : (k < 40) ? 4'd2 : (k < 60) ? 4'd1 : 4'd0;
            push("s1", k, k == 60, k >= 1 && k <= 59, k >= 60, 1'b1, s);
        end

        // Periodic, limit 2
        reset_idle("s2rst");
        for (int k = 0; k <= 125; k++) begin
            drive(1'b0, k == 0, 1'b0, 1'b1, (k == 0) ? 4'd2 : rnd4(),
                  (k == 0) ? 1'b1 : 1'($urandom_range(1)));
            push("s2", k, k == 40 || k == 80 || k == 120, k >= 1, 1'b0, 1'b0, 4'd0);
        end

        // One-shot, limit 1, enable low for 7 cycles
        reset_idle("s3rst");
        for (int k = 0; k <= 35; k++) begin
            drive(1'b0, k == 0, 1'b0, !(k >= 10 && k <= 16), 4'd1, 1'b0);
            push("s3", k, k == 27, k >= 1 && k <= 26, k >= 27, 1'b0, 4'd0);
        end

        // Retrigger at 30 with limit 2, then start+stop together, then stop alone
        reset_idle("s4rst");
        for (int k = 0; k <= 90; k++) begin
            drive(1'b0, k == 0 || k == 30 || k == 80, k == 80 || k == 85, 1'b1,
                  (k == 30) ? 4'd2 : 4'd3, 1'b0);
            push("s4", k, k == 70, (k >= 1 && k <= 69) || (k >= 81 && k <= 85),
                 k >= 70 && k <= 80, 1'b0, 4'd0);
        end

        // Reset mid-run
        reset_idle("s5rst");
        for (int k = 0; k <= 65; k++) begin
            drive(k == 50, k == 0, 1'b0, 1'b1, 4'd3, 1'b0);
            push("s5", k, 1'b0, k >= 1 && k <= 50, 1'b0, k >= 51, 4'd0);
        end

        // limit 0: immediate expiry
        reset_idle("s6rst");
        for (int k = 0; k <= 5; k++) begin
            drive(1'b0, k == 0, 1'b0, 1'b1, 4'd0, 1'b0);
            push("s6", k, k == 1, 1'b0, k >= 1, 1'b1, 4'd0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
